// File: rtl/coin_pkg.sv
// Shared definitions for the coin acceptor and its downstream vending machine.
// Coin codes here must stay identical to the ones vending_machine decodes.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    localparam int TALLY_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Audit counters stick at all-ones instead of wrapping.
    function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser, symmetric debouncer and a
// registered one-cycle pulse on each debounced 0->1 transition.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [1:0] sync;
    logic       level;
    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            rise <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // Enough consecutive disagreeing samples: adopt the new level.
                level <= sync[1];
                cnt   <= '0;
                rise  <= sync[1];
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: debounced sensor events become single-cycle coin codes,
// with lock/spacing rejection and saturating audit tallies.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MIN_GAP         = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coin5_i,
    input  logic               coin10_i,
    input  logic               lock,
    output logic [1:0]         coin,
    output logic               reject,
    output logic [TALLY_W-1:0] tally5,
    output logic [TALLY_W-1:0] tally10
);

    localparam int         NUM_CH   = 2;
    localparam logic [7:0] GAP_LOAD = 8'(MIN_GAP);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] rise;

    assign raw = {coin10_i, coin5_i};

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            coin_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw[g]),
                .rise (rise[g])
            );
        end
    endgenerate

    state_t     state, state_nxt;
    logic [7:0] gap_cnt, gap_nxt;
    logic [1:0] coin_nxt;
    logic       reject_nxt;
    logic       inc5, inc10;

    always_comb begin
        state_nxt  = state;
        gap_nxt    = gap_cnt;
        coin_nxt   = COIN_NONE;
        reject_nxt = 1'b0;
        inc5       = 1'b0;
        inc10      = 1'b0;
        case (state)
            IDLE: begin
                if (rise == 2'b11) begin
                    // Ambiguous simultaneous coins are refused as one event.
                    reject_nxt = 1'b1;
                end else if (rise != 2'b00) begin
                    if (lock) begin
                        reject_nxt = 1'b1;
                    end else begin
                        state_nxt = EMIT;
                        coin_nxt  = rise[0] ? COIN_5 : COIN_10;
                        inc5      = rise[0];
                        inc10     = rise[1];
                    end
                end
            end
            EMIT: begin
                state_nxt  = GAP;
                gap_nxt    = GAP_LOAD;
                reject_nxt = |rise;
            end
            GAP: begin
                reject_nxt = |rise;
                gap_nxt    = gap_cnt - 8'd1;
                if (gap_cnt == 8'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            coin    <= COIN_NONE;
            reject  <= 1'b0;
            tally5  <= '0;
            tally10 <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
            coin    <= coin_nxt;
            reject  <= reject_nxt;
            if (inc5)  tally5  <= sat_inc(tally5);
            if (inc10) tally10 <= sat_inc(tally10);
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised and directed bench for coin_acceptor against a sample-history
// reference model of debouncing, acceptance windows and tallies.
module tb_coin_acceptor;
    import coin_pkg::*;

    localparam int DB = 4;
    localparam int MG = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin5_i = 1'b0;
    logic       coin10_i = 1'b0;
    logic       lock = 1'b0;
    logic [1:0] coin;
    logic       reject;
    logic [7:0] tally5;
    logic [7:0] tally10;

    int n_chk = 0;
    int n_err = 0;

    coin_acceptor #(
        .DEBOUNCE_CYCLES(DB),
        .MIN_GAP        (MG)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .coin5_i (coin5_i),
        .coin10_i(coin10_i),
        .lock    (lock),
        .coin    (coin),
        .reject  (reject),
        .tally5  (tally5),
        .tally10 (tally10)
    );

    always #5 clk = ~clk;

    // Reference model: raw history per channel, bit i = raw sampled i edges ago.
    logic [63:0] hist [2];
    bit          lvl [2];
    bit          ev_prev [2];
    int          edge_n = 0;
    int          last_emit;
    int          m_t5, m_t10;
    int          exp_coin;
    bit          exp_rej;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic m_reset();
        hist[0] = '0; hist[1] = '0;
        lvl[0] = 1'b0; lvl[1] = 1'b0;
        ev_prev[0] = 1'b0; ev_prev[1] = 1'b0;
        last_emit = -1000;
        m_t5 = 0; m_t10 = 0;
        exp_coin = 0; exp_rej = 1'b0;
    endtask

    task automatic m_edge();
        int ne;
        bit idle;
        bit all_opp;
        bit ev [2];
        ne   = int'(ev_prev[0]) + int'(ev_prev[1]);
        idle = (edge_n >= last_emit + MG + 2);
        exp_coin = 0;
        exp_rej  = 1'b0;
        if (ne == 1 && idle && !lock) begin
            if (ev_prev[0]) begin
                exp_coin = 1;
                if (m_t5 < 255) m_t5++;
            end else begin
                exp_coin = 2;
                if (m_t10 < 255) m_t10++;
            end
            last_emit = edge_n;
        end else if (ne > 0) begin
            exp_rej = 1'b1;
        end
        hist[0] = {hist[0][62:0], coin5_i};
        hist[1] = {hist[1][62:0], coin10_i};
        for (int c = 0; c < 2; c++) begin
            // Synchronised samples are the raw values two edges old.
            all_opp = 1'b1;
            for (int i = 2; i <= DB + 1; i++)
                if (hist[c][i] == lvl[c]) all_opp = 1'b0;
            ev[c] = 1'b0;
            if (all_opp) begin
                lvl[c] = ~lvl[c];
                ev[c]  = lvl[c];
            end
        end
        ev_prev = ev;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) m_reset();
        else      m_edge();
        edge_n++;
        #1;
        check("coin",    32'(coin),    32'(exp_coin));
        check("reject",  32'(reject),  32'(exp_rej));
        check("tally5",  32'(tally5),  32'(m_t5));
        check("tally10", 32'(tally10), 32'(m_t10));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input int ch, input int hi, input int lo);
        if (ch == 0) coin5_i = 1'b1;
        else         coin10_i = 1'b1;
        run(hi);
        coin5_i  = 1'b0;
        coin10_i = 1'b0;
        run(lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        m_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_coin",    32'(coin),    32'd0);
        check("rst_reject",  32'(reject),  32'd0);
        check("rst_tally5",  32'(tally5),  32'd0);
        check("rst_tally10", 32'(tally10), 32'd0);
        run(2);
        rst = 1'b1;
        run(3);

        // Clean 5 coin: code must appear on edge DB+3.
        coin5_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == DB + 2) check("clean_pre", 32'(coin), 32'd0);
            if (i == DB + 3) check("clean_edge", 32'(coin), 32'(COIN_5));
        end
        coin5_i = 1'b0;
        run(15);
        check("clean_t5", 32'(tally5), 32'd1);

        // Bouncing 10 coin.
        coin10_i = 1'b1; tick();
        coin10_i = 1'b0; tick();
        coin10_i = 1'b1; run(8);
        coin10_i = 1'b0; run(15);
        check("bounce_t10", 32'(tally10), 32'd1);

        // 5-5-5-10-10 sequence.
        pulse(0, 10, 12); pulse(0, 10, 12); pulse(0, 10, 12);
        pulse(1, 10, 12); pulse(1, 10, 12);
        check("seq_t5",  32'(tally5),  32'd4);
        check("seq_t10", 32'(tally10), 32'd3);

        // Second coin debounced while in GAP is refused.
        coin5_i = 1'b1; tick(); tick();
        coin10_i = 1'b1; run(10);
        coin5_i = 1'b0; coin10_i = 1'b0; run(15);
        check("gap_t5",  32'(tally5),  32'd5);
        check("gap_t10", 32'(tally10), 32'd3);

        // Lock high in IDLE.
        lock = 1'b1;
        pulse(0, 10, 15);
        lock = 1'b0;
        check("lock_t5", 32'(tally5), 32'd5);

        // Both sensors rise together.
        coin5_i = 1'b1; coin10_i = 1'b1; run(10);
        coin5_i = 1'b0; coin10_i = 1'b0; run(15);
        check("both_t5",  32'(tally5),  32'd5);
        check("both_t10", 32'(tally10), 32'd3);

        // Random bouncing sensors and lock.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(5) == 0) coin5_i  = ~coin5_i;
            if ($urandom_range(5) == 0) coin10_i = ~coin10_i;
            if ($urandom_range(9) == 0) lock     = ~lock;
            tick();
        end

        // Asynchronous reset in the middle of EMIT.
        coin5_i = 1'b0; coin10_i = 1'b0; lock = 1'b0;
        run(20);
        coin5_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (exp_coin != 0) found = 1'b1;
        end
        check("emit_reached", 32'(found), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_coin",    32'(coin),    32'd0);
        check("arst_tally5",  32'(tally5),  32'd0);
        check("arst_tally10", 32'(tally10), 32'd0);
        m_reset();
        run(2);
        rst = 1'b1;
        run(12);
        coin5_i = 1'b0;
        run(15);
        check("rel_t5", 32'(tally5), 32'd1);

        // Saturation of tally5.
        for (int i = 0; i < 260; i++) pulse(0, 6, 8);
        check("sat_t5",  32'(tally5),  32'd255);
        check("sat_t10", 32'(tally10), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
